feature_epoch_ctrl: RTL and testbench
=====================================

FEATURE_EPOCH_CTRL -- requirements
Module: feature_epoch_ctrl

Interface
REQ-001 SHALL have parameter EPOCH_LENGTH, default 256, samples per epoch (>=2).
REQ-002 SHALL have parameter RES_W, default 8, engine result width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max cycles waited for eng_done.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  pulse, begin epoch sequencing.
REQ-007 SHALL have port stop  input  1  pulse, end sequencing.
REQ-008 SHALL have port s_valid  input  1  upstream sample available.
REQ-009 SHALL have port s_ready  output  1  controller accepts sample.
REQ-010 SHALL have port eng_en  output  1  engine enable, level.
REQ-011 SHALL have port eng_clr  output  1  engine clear, one-cycle pulse.
REQ-012 SHALL have port eng_step  output  1  one pulse per accepted sample.
REQ-013 SHALL have port eng_done  input  1  engine result ready.
REQ-014 SHALL have port eng_result  input  RES_W  engine feature value.
REQ-015 SHALL have port m_valid  output  1  result available downstream.
REQ-016 SHALL have port m_ready  input  1  downstream accepts result.
REQ-017 SHALL have port m_data  output  RES_W  captured feature value.
REQ-018 SHALL have port m_epoch  output  16  index of epoch in m_data.
REQ-019 SHALL have port busy  output  1  high in any state except IDLE.
REQ-020 SHALL have port timeout_err  output  1  sticky, engine missed TIMEOUT.

Function
REQ-021 SHALL implement FSM states IDLE, CLEAR, COLLECT, WAIT_ENG, OUTPUT.
REQ-022 SHALL move IDLE->CLEAR on start=1 and stop=0; start with stop=1 in IDLE ignored.
REQ-023 SHALL assert eng_clr=1 for exactly the single CLEAR cycle, clear sample counter, then enter COLLECT.
REQ-024 SHALL drive s_ready=1 only in COLLECT; eng_step=s_valid&s_ready, combinational.
REQ-025 SHALL increment sample counter ($clog2(EPOCH_LENGTH) bits) per accepted sample; acceptance of sample EPOCH_LENGTH moves to WAIT_ENG next cycle, counter wraps to 0.
REQ-026 SHALL, in WAIT_ENG, on eng_done=1 register eng_result into m_data, assert m_valid next cycle, enter OUTPUT.
REQ-027 SHALL count WAIT_ENG cycles; after TIMEOUT cycles without eng_done set timeout_err=1, produce no output, go to CLEAR (or IDLE if stop pending).
REQ-028 SHALL hold m_valid, m_data, m_epoch stable in OUTPUT until m_valid&m_ready.
REQ-029 SHALL, on OUTPUT handshake, deassert m_valid next cycle, increment m_epoch (wrap 0xFFFF->0), go to CLEAR, or IDLE if stop pending.
REQ-030 SHALL treat stop in COLLECT as abort: go to IDLE next cycle, discard partial epoch, no output, m_epoch unchanged.
REQ-031 SHALL latch stop in CLEAR, WAIT_ENG, OUTPUT as stop_pending; current epoch completes; stop_pending cleared on entering IDLE.
REQ-032 SHALL ignore start whenever busy=1.
REQ-033 SHALL drive eng_en=busy.
REQ-034 SHALL keep timeout_err set until rst; start does not clear it.

Reset
REQ-035 SHALL on rst force IDLE, s_ready=0, eng_en=0, eng_clr=0, m_valid=0, m_data=0, m_epoch=0, busy=0, timeout_err=0, counters and stop_pending 0.
REQ-036 SHALL, on rst mid-epoch, discard all epoch state; after release wait for new start.

Verification (EPOCH_LENGTH=4, RES_W=8, TIMEOUT=16)
REQ-037 SHALL test nominal: start, 4 samples back-to-back, eng_done with eng_result=0x05 two cycles later, m_ready=1 -> m_data=0x05, m_epoch=0, then eng_clr pulse, s_ready=1 again.
REQ-038 SHALL test backpressure: m_ready=0 for 10 cycles -> m_valid/m_data stable, s_ready=0; m_ready=1 -> m_epoch increments to 1.
REQ-039 SHALL test stop in COLLECT after 2 samples -> IDLE next cycle, no m_valid, busy=0, m_epoch unchanged.
REQ-040 SHALL test stop in WAIT_ENG -> result 0x03 still output, then IDLE, no eng_clr.
REQ-041 SHALL test timeout: no eng_done for 16 cycles -> timeout_err=1, no m_valid, eng_clr pulse, COLLECT resumes.
REQ-042 SHALL test async rst asserted in OUTPUT -> all outputs zero immediately, start then restarts at m_epoch=0.

Source files
------------

// File: rtl/feature_epoch_ctrl.sv
// rtl/feature_epoch_ctrl.sv - epoch sequencer between a sample stream, a feature engine and a result stream
module feature_epoch_ctrl #(
    parameter int EPOCH_LENGTH = 256,
    parameter int RES_W        = 8,
    parameter int TIMEOUT      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             eng_en,
    output logic             eng_clr,
    output logic             eng_step,
    input  logic             eng_done,
    input  logic [RES_W-1:0] eng_result,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [RES_W-1:0] m_data,
    output logic [15:0]      m_epoch,
    output logic             busy,
    output logic             timeout_err
);

    localparam int CNT_W = $clog2(EPOCH_LENGTH);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(EPOCH_LENGTH - 1);
    localparam logic [TMO_W-1:0] LAST_WAIT   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COLLECT,
        WAIT_ENG,
        OUTPUT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;
    logic [TMO_W-1:0] wait_cnt;
    logic             stop_pending;
    logic             stop_now;

    // A stop arriving in the same cycle as the epoch ends still counts as pending.
    assign stop_now = stop_pending | stop;

    assign busy     = (state != IDLE);
    assign eng_en   = busy;
    assign eng_clr  = (state == CLEAR);
    assign s_ready  = (state == COLLECT);
    assign m_valid  = (state == OUTPUT);
    assign eng_step = s_valid & s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sample_cnt   <= '0;
            wait_cnt     <= '0;
            stop_pending <= 1'b0;
            m_data       <= '0;
            m_epoch      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stop_pending <= 1'b0;
                    if (start && !stop) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    sample_cnt <= '0;
                    wait_cnt   <= '0;
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    state <= COLLECT;
                end
                COLLECT: begin
                    if (stop) begin
                        // Abort: the partial epoch is dropped without any output.
                        sample_cnt   <= '0;
                        stop_pending <= 1'b0;
                        state        <= IDLE;
                    end else if (s_valid) begin
                        if (sample_cnt == LAST_SAMPLE) begin
                            sample_cnt <= '0;
                            wait_cnt   <= '0;
                            state      <= WAIT_ENG;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                WAIT_ENG: begin
                    if (eng_done) begin
                        m_data       <= eng_result;
                        stop_pending <= stop_now;
                        state        <= OUTPUT;
                    end else if (wait_cnt == LAST_WAIT) begin
                        timeout_err  <= 1'b1;
                        stop_pending <= 1'b0;
                        state        <= stop_now ? IDLE : CLEAR;
                    end else begin
                        wait_cnt     <= wait_cnt + 1'b1;
                        stop_pending <= stop_now;
                    end
                end
                OUTPUT: begin
                    if (m_ready) begin
                        m_epoch      <= m_epoch + 16'd1;
                        stop_pending <= 1'b0;
                        state        <= stop_now ? IDLE : CLEAR;
                    end else begin
                        stop_pending <= stop_now;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feature_epoch_ctrl.sv
// tb/tb_feature_epoch_ctrl.sv - directed and randomized checks of feature_epoch_ctrl against a transaction-level model
module tb_feature_epoch_ctrl;

    localparam int EL  = 4;
    localparam int RW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          s_valid;
    logic          s_ready;
    logic          eng_en;
    logic          eng_clr;
    logic          eng_step;
    logic          eng_done;
    logic [RW-1:0] eng_result;
    logic          m_valid;
    logic          m_ready;
    logic [RW-1:0] m_data;
    logic [15:0]   m_epoch;
    logic          busy;
    logic          timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    feature_epoch_ctrl #(
        .EPOCH_LENGTH(EL),
        .RES_W       (RW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .eng_en     (eng_en),
        .eng_clr    (eng_clr),
        .eng_step   (eng_step),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_epoch    (m_epoch),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        s_valid    = 1'b0;
        eng_done   = 1'b0;
        eng_result = '0;
        m_ready    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_epoch();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clr", eng_clr, 1);
        tick();
        check("start_clr_once", eng_clr, 0);
        check("start_collect", s_ready, 1);
    endtask

    task automatic feed(input int n);
        s_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("feed_step", eng_step, 1);
            tick();
        end
        s_valid = 1'b0;
    endtask

    int      exp_epoch;
    bit      exp_tmo;
    int      accepted;
    int      guard;
    int      d;
    int      b;
    logic [RW-1:0] r;

    initial begin
        do_reset();
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_sready", s_ready, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_epoch", m_epoch, 0);
        check("rst_tmo", timeout_err, 0);
        rst = 1'b0;
        tick();

        // start together with stop in IDLE is ignored
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_ign", busy, 0);

        // nominal epoch
        start_epoch();
        feed(EL);
        check("nom_wait_sready", s_ready, 0);
        check("nom_wait_en", eng_en, 1);
        tick();
        tick();
        eng_done   = 1'b1;
        eng_result = 8'h05;
        tick();
        eng_done = 1'b0;
        check("nom_mvalid", m_valid, 1);
        check("nom_mdata", m_data, 8'h05);
        check("nom_mepoch", m_epoch, 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("nom_mvalid_drop", m_valid, 0);
        check("nom_clr", eng_clr, 1);
        check("nom_epoch_inc", m_epoch, 1);
        tick();
        check("nom_sready", s_ready, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // backpressure from a fresh reset
        do_reset();
        start_epoch();
        feed(EL);
        eng_done   = 1'b1;
        eng_result = 8'hA7;
        tick();
        eng_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_mvalid", m_valid, 1);
            check("bp_mdata", m_data, 8'hA7);
            check("bp_sready", s_ready, 0);
            tick();
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("bp_epoch", m_epoch, 1);
        tick();

        // stop in COLLECT after two samples
        feed(2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_mvalid", m_valid, 0);
        check("abort_epoch", m_epoch, 1);

        // stop in WAIT_ENG still delivers the result
        start_epoch();
        feed(EL);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("wstop_busy", busy, 1);
        eng_done   = 1'b1;
        eng_result = 8'h03;
        tick();
        eng_done = 1'b0;
        check("wstop_mvalid", m_valid, 1);
        check("wstop_mdata", m_data, 8'h03);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("wstop_idle", busy, 0);
        check("wstop_noclr", eng_clr, 0);
        check("wstop_epoch", m_epoch, 2);

        // engine timeout
        start_epoch();
        feed(EL);
        repeat (TMO - 1) tick();
        check("tmo_early", timeout_err, 0);
        check("tmo_wait_busy", busy, 1);
        tick();
        check("tmo_err", timeout_err, 1);
        check("tmo_clr", eng_clr, 1);
        check("tmo_nomvalid", m_valid, 0);
        check("tmo_epoch", m_epoch, 2);
        tick();
        check("tmo_resume", s_ready, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        start_epoch();
        check("tmo_sticky", timeout_err, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // asynchronous reset while in OUTPUT
        do_reset();
        start_epoch();
        feed(EL);
        eng_done   = 1'b1;
        eng_result = 8'h11;
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();
        feed(EL);
        eng_result = 8'h22;
        tick();
        eng_done = 1'b0;
        check("arst_pre_mvalid", m_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mvalid", m_valid, 0);
        check("arst_mdata", m_data, 0);
        check("arst_epoch", m_epoch, 0);
        check("arst_busy", busy, 0);
        check("arst_en", eng_en, 0);
        tick();
        rst = 1'b0;
        tick();
        start_epoch();
        feed(EL);
        eng_done   = 1'b1;
        eng_result = 8'h33;
        tick();
        eng_done = 1'b0;
        check("arst_restart_epoch", m_epoch, 0);
        check("arst_restart_data", m_data, 8'h33);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // randomized epochs against a transaction-level model
        do_reset();
        exp_epoch = 0;
        exp_tmo   = 1'b0;
        start_epoch();
        for (int ep = 0; ep < 40; ep++) begin
            accepted = 0;
            guard    = 0;
            while (accepted < EL && guard < 200) begin
                s_valid    = 1'($urandom % 2);
                eng_done   = ($urandom % 4) == 0;
                eng_result = 8'($urandom);
                start      = ($urandom % 8) == 0;
                #1;
                check("rnd_step", eng_step, s_valid);
                tick();
                if (s_valid) accepted++;
                guard++;
            end
            s_valid  = 1'b0;
            eng_done = 1'b0;
            start    = 1'b0;
            check("rnd_collect_done", accepted, EL);
            check("rnd_wait_sready", s_ready, 0);
            check("rnd_wait_busy", busy, 1);
            d = $urandom_range(0, 20);
            r = 8'($urandom);
            if (d < TMO) begin
                repeat (d) tick();
                check("rnd_no_early_out", m_valid, 0);
                eng_done   = 1'b1;
                eng_result = r;
                tick();
                eng_done = 1'b0;
                check("rnd_mvalid", m_valid, 1);
                check("rnd_mdata", m_data, r);
                check("rnd_mepoch", m_epoch, 16'(exp_epoch));
                b = $urandom_range(0, 3);
                for (int i = 0; i < b; i++) begin
                    tick();
                    check("rnd_hold_data", m_data, r);
                    check("rnd_hold_valid", m_valid, 1);
                end
                m_ready = 1'b1;
                tick();
                m_ready = 1'b0;
                exp_epoch++;
                check("rnd_epoch_inc", m_epoch, 16'(exp_epoch));
                check("rnd_clr", eng_clr, 1);
                check("rnd_mvalid_drop", m_valid, 0);
            end else begin
                repeat (TMO) tick();
                exp_tmo = 1'b1;
                check("rnd_tmo_clr", eng_clr, 1);
                check("rnd_tmo_nomvalid", m_valid, 0);
                check("rnd_tmo_epoch", m_epoch, 16'(exp_epoch));
            end
            check("rnd_tmo_flag", timeout_err, exp_tmo);
            tick();
            check("rnd_resume", s_ready, 1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("rnd_end_idle", busy, 0);
        check("rnd_end_epoch", m_epoch, 16'(exp_epoch));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
